// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Round-robin on ties, one operation in flight, registered response with back-pressure.
module alu_share_arb #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_f,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_f,
   output logic             req1_ready,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_f,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_zero,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_y,
   output logic             rsp_zero,
   input  logic             rsp_ready
);

   // state | meaning
   // IDLE  | sample requests, grant one, latch its operands
   // EXEC  | shared ALU evaluates latched operands; result captured
   // RESP  | result presented until rsp_ready
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [2:0]       op_f_q, op_f_d;
   logic             op_id_q, op_id_d;
   logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_id_q, rsp_id_d;
   logic             last_grant_q, last_grant_d;
   logic             gnt0, gnt1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_f_q       <= '0;
         op_id_q      <= 1'b0;
         rsp_y_q      <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_f_q       <= op_f_d;
         op_id_q      <= op_id_d;
         rsp_y_q      <= rsp_y_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_id_q     <= rsp_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Requester 0 wins a tie only when requester 1 was granted last.
   assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
   assign gnt1 = req1_valid & ~gnt0;

   always_comb begin
      state_d      = state_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_f_d       = op_f_q;
      op_id_d      = op_id_q;
      rsp_y_d      = rsp_y_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_id_d     = rsp_id_q;
      last_grant_d = last_grant_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      rsp_valid    = 1'b0;
      case (state_q)
         IDLE: begin
            req0_ready = gnt0;
            req1_ready = gnt1;
            if (gnt0 || gnt1) begin
               op_a_d       = gnt1 ? req1_a : req0_a;
               op_b_d       = gnt1 ? req1_b : req0_b;
               op_f_d       = gnt1 ? req1_f : req0_f;
               op_id_d      = gnt1;
               last_grant_d = gnt1;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            rsp_y_d    = alu_y;
            rsp_zero_d = alu_zero;
            rsp_id_d   = op_id_q;
            state_d    = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign alu_a    = op_a_q;
   assign alu_b    = op_b_q;
   assign alu_f    = op_f_q;
   assign rsp_y    = rsp_y_q;
   assign rsp_zero = rsp_zero_q;
   assign rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed vector table, hand-written corner sequences,
// then random traffic checked against a transaction-level model.
module tb_alu_share_arb;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic [2:0]    req0_f, req1_f;
   logic [W-1:0]  alu_a, alu_b, alu_y, rsp_y;
   logic [2:0]    alu_f;
   logic          alu_zero, rsp_valid, rsp_id, rsp_zero, rsp_ready;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_share_arb #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f), .req1_ready(req1_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_ready(rsp_ready)
   );

   // Shared ALU in the environment
   function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] f);
      case (f)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd3:    return a ^ b;
         3'd4:    return a << b[4:0];
         3'd5:    return a >> b[4:0];
         3'd6:    return a - b;
         default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
   endfunction

   always_comb begin
      alu_y    = alu_ref(alu_a, alu_b, alu_f);
      alu_zero = (alu_y == '0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic quiet_inputs();
      req0_valid = 0; req1_valid = 0;
      req0_a = '0; req0_b = '0; req0_f = '0;
      req1_a = '0; req1_b = '0; req1_f = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_alu_a"}, alu_a, 0);
      chk({tag, "_alu_b"}, alu_b, 0);
      chk({tag, "_alu_f"}, alu_f, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_y"}, rsp_y, 0);
      chk({tag, "_rsp_zero"}, rsp_zero, 0);
      chk({tag, "_rsp_id"}, rsp_id, 0);
      chk({tag, "_readys"}, {req0_ready, req1_ready}, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      quiet_inputs();
      reset = 1;
      #1 check_all_zero("rst");
      @(negedge clk);
      reset = 0;
   endtask

   typedef struct {
      logic         v0;
      logic [W-1:0] a0, b0;
      logic [2:0]   f0;
      logic         v1;
      logic [W-1:0] a1, b1;
      logic [2:0]   f1;
      logic         id;
      logic [W-1:0] y;
      logic         z;
   } vec_t;

   vec_t tbl[6];

   task automatic apply_vec(input vec_t v, input int idx);
      string s;
      s = $sformatf("vec%0d", idx);
      @(negedge clk);
      req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_f = v.f0;
      req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_f = v.f1;
      rsp_ready = 1;
      #1;
      chk({s, "_ready0"}, req0_ready, !v.id);
      chk({s, "_ready1"}, req1_ready, v.id);
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      req0_a = $urandom; req0_f = 3'($urandom); req1_a = $urandom; req1_f = 3'($urandom);
      #1;
      chk({s, "_exec_valid"}, rsp_valid, 0);
      chk({s, "_alu_f"}, alu_f, v.id ? v.f1 : v.f0);
      @(negedge clk);
      #1;
      chk({s, "_rsp_valid"}, rsp_valid, 1);
      chk({s, "_rsp_id"}, rsp_id, v.id);
      chk({s, "_rsp_y"}, rsp_y, v.y);
      chk({s, "_rsp_zero"}, rsp_zero, v.z);
      @(negedge clk);
      #1 chk({s, "_done"}, rsp_valid, 0);
   endtask

   // Transaction-level reference model state
   logic         m_pend, m_id, m_z, m_last;
   int           m_age;
   logic [W-1:0] m_y, m_a, m_b;
   logic [2:0]   m_f;

   initial begin
      logic [W-1:0] y_hold;
      int grants[$];

      quiet_inputs();
      rsp_ready = 0;
      reset = 1;
      #1 check_all_zero("por");
      @(negedge clk);
      reset = 0;

      //         v0  a0            b0            f0    v1  a1            b1            f1    id  y             z
      tbl[0] = '{1, 32'h00000005, 32'h00000003, 3'b010, 0, 32'h0,        32'h0,        3'b000, 0, 32'h00000008, 0};
      tbl[1] = '{0, 32'h0,        32'h0,        3'b000, 1, 32'h12345678, 32'h12345678, 3'b110, 1, 32'h00000000, 1};
      tbl[2] = '{1, 32'hFFFFFFFF, 32'h00000001, 3'b010, 1, 32'h00000004, 32'h00000004, 3'b001, 0, 32'h00000000, 1};
      tbl[3] = '{1, 32'h00000001, 32'h00000002, 3'b000, 1, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b011, 1, 32'hFF00FF00, 0};
      tbl[4] = '{0, 32'h0,        32'h0,        3'b000, 1, 32'hA5A5A5A5, 32'h0F0F0F0F, 3'b000, 1, 32'h05050505, 0};
      tbl[5] = '{1, 32'hFFFFFFFF, 32'h00000001, 3'b111, 0, 32'h0,        32'h0,        3'b000, 0, 32'h00000001, 0};
      for (int i = 0; i < 6; i++) apply_vec(tbl[i], i);

      // Contention: both held high across four operations
      do_reset();
      @(negedge clk);
      req0_valid = 1; req0_a = 32'h10; req0_b = 32'h1; req0_f = 3'b010;
      req1_valid = 1; req1_a = 32'h20; req1_b = 32'h2; req1_f = 3'b110;
      rsp_ready = 1;
      for (int c = 0; c < 20 && grants.size() < 4; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         chk("one_ready", req0_ready & req1_ready, 0);
         if (req0_ready) grants.push_back(0);
         else if (req1_ready) grants.push_back(1);
      end
      chk("grant_count", grants.size(), 4);
      for (int i = 0; i < grants.size(); i++) chk($sformatf("grant%0d", i), grants[i], i % 2);
      @(negedge clk);
      quiet_inputs();
      repeat (3) @(negedge clk);

      // Back-pressure: response held for several cycles, requester 1 waiting
      req0_valid = 1; req0_a = 32'd7; req0_b = 32'd9; req0_f = 3'b010;
      rsp_ready = 0;
      #1 chk("bp_accept", req0_ready, 1);
      @(negedge clk);
      req0_valid = 0; req1_valid = 1; req1_a = 32'd100; req1_b = 32'd1; req1_f = 3'b110;
      #1 chk("bp_exec_readys", {req0_ready, req1_ready}, 0);
      @(negedge clk);
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_y", rsp_y, 16);
      y_hold = rsp_y;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         chk("bp_hold_valid", rsp_valid, 1);
         chk("bp_hold_y", rsp_y, 16);
         chk("bp_hold_readys", {req0_ready, req1_ready}, 0);
      end
      rsp_ready = 1;
      @(negedge clk);
      #1;
      chk("bp_release_valid", rsp_valid, 0);
      chk("bp_release_ready1", req1_ready, 1);
      req1_valid = 0;

      // Reset during EXEC with last grant = requester 0
      @(negedge clk);
      req0_valid = 1; req0_a = 32'h11; req0_b = 32'h22; req0_f = 3'b011;
      #1 chk("rm_accept", req0_ready, 1);
      @(negedge clk);
      req0_valid = 0;
      #1 chk("rm_exec_alu_a", alu_a, 32'h11);
      reset = 1;
      #1 check_all_zero("rm");
      @(negedge clk);
      reset = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1 chk("rm_no_rsp", rsp_valid, 0);
      end
      req0_valid = 1; req1_valid = 1; req0_a = 32'd3; req1_a = 32'd4;
      #1;
      chk("rm_tie_ready0", req0_ready, 1);
      chk("rm_tie_ready1", req1_ready, 0);
      @(negedge clk);
      quiet_inputs();
      repeat (3) @(negedge clk);

      // Random traffic against the transaction model
      do_reset();
      m_pend = 0; m_age = 0; m_id = 0; m_y = '0; m_z = 0; m_last = 1;
      m_a = '0; m_b = '0; m_f = '0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         logic g0, g1, ev;
         @(negedge clk);
         req0_valid = ($urandom_range(0, 2) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
         req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
         req0_f = 3'($urandom); req1_f = 3'($urandom);
         rsp_ready = ($urandom_range(0, 2) != 0);
         #1;
         g0 = !m_pend && req0_valid && (!req1_valid || m_last);
         g1 = !m_pend && req1_valid && !g0;
         ev = m_pend && (m_age >= 2);
         chk("rnd_ready0", req0_ready, g0);
         chk("rnd_ready1", req1_ready, g1);
         chk("rnd_rsp_valid", rsp_valid, ev);
         chk("rnd_alu_ops", {alu_f, alu_a, alu_b}, {m_f, m_a, m_b});
         if (ev) begin
            chk("rnd_rsp_id", rsp_id, m_id);
            chk("rnd_rsp_y", rsp_y, m_y);
            chk("rnd_rsp_zero", rsp_zero, m_z);
         end
         if (m_pend) begin
            if (ev && rsp_ready) m_pend = 0;
            else m_age++;
         end else if (g0 || g1) begin
            m_pend = 1;
            m_age  = 1;
            m_id   = g1;
            m_last = g1;
            m_a    = g1 ? req1_a : req0_a;
            m_b    = g1 ? req1_b : req0_b;
            m_f    = g1 ? req1_f : req0_f;
            m_y    = alu_ref(m_a, m_b, m_f);
            m_z    = (m_y == '0);
         end
      end
      @(negedge clk);
      quiet_inputs();
      rsp_ready = 1;
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
